// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit/receive blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_t;

  localparam int MAX_DATA_BITS = 9;

  // Data narrower than MAX_DATA_BITS must arrive zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_bit(parity_t mode, logic [MAX_DATA_BITS-1:0] data);
    logic p_s;
    case (mode)
      PAR_EVEN: p_s = ^data;
      PAR_ODD:  p_s = ~^data;
      default:  p_s = 1'b0;
    endcase
    return p_s;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side valid/ready handshake into the UART transmit FIFO.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with extra-bit pointers and registered full/empty/level flags.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      wr_nxt_s;
  logic [AW:0]      rd_nxt_s;
  logic             do_push_s;
  logic             do_pop_s;
  logic             full_r;
  logic             empty_r;
  logic [LW-1:0]    level_r;
  logic [WIDTH-1:0] mem_r [DEPTH];

  assign do_push_s = push & ~full_r;
  assign do_pop_s  = pop & ~empty_r;

  // Next pointer values; flags are derived from these so they are valid the cycle after a change.
  always_comb begin
    wr_nxt_s = wr_ptr_r;
    rd_nxt_s = rd_ptr_r;
    if (do_push_s) begin
      wr_nxt_s = wr_ptr_r + (AW+1)'(1'b1);
    end else begin
      wr_nxt_s = wr_ptr_r;
    end
    if (do_pop_s) begin
      rd_nxt_s = rd_ptr_r + (AW+1)'(1'b1);
    end else begin
      rd_nxt_s = rd_ptr_r;
    end
  end

  // Pointer and status registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      level_r  <= '0;
    end else begin
      wr_ptr_r <= wr_nxt_s;
      rd_ptr_r <= rd_nxt_s;
      full_r   <= (wr_nxt_s[AW] != rd_nxt_s[AW]) && (wr_nxt_s[AW-1:0] == rd_nxt_s[AW-1:0]);
      empty_r  <= (wr_nxt_s == rd_nxt_s);
      level_r  <= LW'(wr_nxt_s - rd_nxt_s);
    end
  end

  // Storage array; contents are don't-care while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

  assign rdata = mem_r[rd_ptr_r[AW-1:0]];
  assign full  = full_r;
  assign empty = empty_r;
  assign level = level_r;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an internal FIFO, with parity/stop options and CTS flow control.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int      DATA_BITS  = 8,
  parameter parity_t PARITY     = PAR_NONE,
  parameter int      STOP_BITS  = 1,
  parameter int      FIFO_DEPTH = 4,
  parameter int      USE_CTS    = 1
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic                            tx_tick,
  uart_tx_fifo_if.slave                   tx_if,
  input  logic                            cts_n,
  output logic                            tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            TX
);

  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS-1);
  localparam logic          STOP_LAST  = 1'(STOP_BITS-1);
  localparam logic          CTS_BYPASS = (USE_CTS == 0);

  tx_state_t            state_r;
  logic                 tx_r;
  logic                 tx_busy_r;
  logic [DATA_BITS-1:0] sh_r;
  logic                 par_r;
  logic [BW-1:0]        bit_i_r;
  logic                 stop_i_r;
  logic                 cts_meta_r;
  logic                 cts_sync_r;

  logic                 cts_ok_s;
  logic                 push_s;
  logic                 start_s;
  logic                 frame_end_s;
  logic                 idle_nxt_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [DATA_BITS-1:0] fifo_rdata_s;
  logic [LW-1:0]        fifo_level_s;
  logic [LW-1:0]        level_nxt_s;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push_s),
    .wdata (tx_if.tx_data),
    .pop   (start_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level_s)
  );

  // Two-flop synchroniser for the asynchronous clear-to-send input; resets to "not clear".
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cts_meta_r <= 1'b1;
      cts_sync_r <= 1'b1;
    end else begin
      cts_meta_r <= cts_n;
      cts_sync_r <= cts_meta_r;
    end
  end

  assign cts_ok_s    = ~cts_sync_r | CTS_BYPASS;
  assign push_s      = tx_if.tx_valid & ~fifo_full_s;
  assign frame_end_s = tx_tick & (state_r == STOP) & (stop_i_r == STOP_LAST);
  assign start_s     = tx_tick & ~fifo_empty_s & cts_ok_s &
                       ((state_r == IDLE) | ((state_r == STOP) & (stop_i_r == STOP_LAST)));
  assign idle_nxt_s  = ~start_s & ((state_r == IDLE) | frame_end_s);

  // FIFO occupancy after this edge, so tx_busy can be registered without lagging a cycle.
  always_comb begin
    level_nxt_s = fifo_level_s;
    if (push_s & ~start_s) begin
      level_nxt_s = fifo_level_s + LW'(1'b1);
    end else if (~push_s & start_s) begin
      level_nxt_s = fifo_level_s - LW'(1'b1);
    end else begin
      level_nxt_s = fifo_level_s;
    end
  end

  // Frame sequencer: every line change is aligned to a bit tick.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r   <= IDLE;
      tx_r      <= 1'b1;
      tx_busy_r <= 1'b0;
      sh_r      <= '0;
      par_r     <= 1'b0;
      bit_i_r   <= '0;
      stop_i_r  <= 1'b0;
    end else begin
      tx_busy_r <= (level_nxt_s != '0) | ~idle_nxt_s;
      if (tx_tick) begin
        case (state_r)
          IDLE: begin
            if (start_s) begin
              sh_r    <= fifo_rdata_s;
              par_r   <= parity_bit(PARITY, MAX_DATA_BITS'(fifo_rdata_s));
              tx_r    <= 1'b0;
              state_r <= START;
            end
          end
          START: begin
            tx_r    <= sh_r[0];
            bit_i_r <= '0;
            state_r <= DATA;
          end
          DATA: begin
            if (bit_i_r == BIT_LAST) begin
              if (PARITY == PAR_NONE) begin
                tx_r     <= 1'b1;
                stop_i_r <= 1'b0;
                state_r  <= STOP;
              end else begin
                tx_r    <= par_r;
                state_r <= PAR;
              end
            end else begin
              // Shift right so the next data bit is always at sh_r[1].
              bit_i_r <= bit_i_r + BW'(1'b1);
              tx_r    <= sh_r[1];
              sh_r    <= sh_r >> 1;
            end
          end
          PAR: begin
            tx_r     <= 1'b1;
            stop_i_r <= 1'b0;
            state_r  <= STOP;
          end
          STOP: begin
            if (stop_i_r == STOP_LAST) begin
              if (start_s) begin
                sh_r    <= fifo_rdata_s;
                par_r   <= parity_bit(PARITY, MAX_DATA_BITS'(fifo_rdata_s));
                tx_r    <= 1'b0;
                state_r <= START;
              end else begin
                tx_r    <= 1'b1;
                state_r <= IDLE;
              end
            end else begin
              stop_i_r <= stop_i_r + 1'b1;
            end
          end
          default: begin
            tx_r    <= 1'b1;
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign tx_if.tx_ready = ~fifo_full_s;
  assign tx_busy        = tx_busy_r;
  assign fifo_level     = fifo_level_s;
  assign TX             = tx_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: several frame formats, FIFO back-pressure, CTS and reset.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic       clk;
  logic       nrst;
  logic       tick;
  logic       cts_n;
  logic [4:0] tx_line;
  logic [4:0] busy;
  logic [2:0] lvl [5];
  int         n_checks;
  int         n_fail;

  uart_tx_fifo_if #(.DATA_BITS(8)) if_n1 ();
  uart_tx_fifo_if #(.DATA_BITS(8)) if_e1 ();
  uart_tx_fifo_if #(.DATA_BITS(8)) if_o1 ();
  uart_tx_fifo_if #(.DATA_BITS(8)) if_n2 ();
  uart_tx_fifo_if #(.DATA_BITS(5)) if_d5 ();

  uart_tx_fifo #(.DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4), .USE_CTS(1)) u_n1 (
    .clk(clk), .nrst(nrst), .tx_tick(tick), .tx_if(if_n1), .cts_n(cts_n),
    .tx_busy(busy[0]), .fifo_level(lvl[0]), .TX(tx_line[0]));
  uart_tx_fifo #(.DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(4), .USE_CTS(1)) u_e1 (
    .clk(clk), .nrst(nrst), .tx_tick(tick), .tx_if(if_e1), .cts_n(1'b0),
    .tx_busy(busy[1]), .fifo_level(lvl[1]), .TX(tx_line[1]));
  uart_tx_fifo #(.DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1), .FIFO_DEPTH(4), .USE_CTS(1)) u_o1 (
    .clk(clk), .nrst(nrst), .tx_tick(tick), .tx_if(if_o1), .cts_n(1'b0),
    .tx_busy(busy[2]), .fifo_level(lvl[2]), .TX(tx_line[2]));
  uart_tx_fifo #(.DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(2), .FIFO_DEPTH(4), .USE_CTS(1)) u_n2 (
    .clk(clk), .nrst(nrst), .tx_tick(tick), .tx_if(if_n2), .cts_n(1'b0),
    .tx_busy(busy[3]), .fifo_level(lvl[3]), .TX(tx_line[3]));
  uart_tx_fifo #(.DATA_BITS(5), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4), .USE_CTS(0)) u_d5 (
    .clk(clk), .nrst(nrst), .tx_tick(tick), .tx_if(if_d5), .cts_n(cts_n),
    .tx_busy(busy[4]), .fifo_level(lvl[4]), .TX(tx_line[4]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-cycle bit tick every 16 clocks, changed on the falling edge.
  initial begin
    tick = 1'b0;
    forever begin
      repeat (15) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_valid(input int ch, input logic v, input logic [7:0] d);
    case (ch)
      0: begin if_n1.tx_valid = v; if_n1.tx_data = d; end
      1: begin if_e1.tx_valid = v; if_e1.tx_data = d; end
      2: begin if_o1.tx_valid = v; if_o1.tx_data = d; end
      3: begin if_n2.tx_valid = v; if_n2.tx_data = d; end
      default: begin if_d5.tx_valid = v; if_d5.tx_data = d[4:0]; end
    endcase
  endtask

  function automatic logic get_ready(input int ch);
    case (ch)
      0: return if_n1.tx_ready;
      1: return if_e1.tx_ready;
      2: return if_o1.tx_ready;
      3: return if_n2.tx_ready;
      default: return if_d5.tx_ready;
    endcase
  endfunction

  function automatic logic get_tx(input int ch);
    case (ch)
      0: return tx_line[0];
      1: return tx_line[1];
      2: return tx_line[2];
      3: return tx_line[3];
      default: return tx_line[4];
    endcase
  endfunction

  task automatic push(input int ch, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    drive_valid(ch, 1'b1, d);
    for (int i = 0; i < 400; i++) begin
      if (get_ready(ch)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      check("push_timeout", 32'd0, 32'd1);
    end
    drive_valid(ch, 1'b0, 8'h00);
  endtask

  task automatic next_tick();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (tick) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    if (!ok) check("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_start(input int ch);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (get_tx(ch) == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("start_timeout", 32'd0, 32'd1);
  endtask

  // Captures a frame with the first line bit in the most significant position.
  task automatic collect(input int ch, input int nbits, output logic [31:0] bits);
    wait_start(ch);
    bits = 32'd0;
    for (int k = 1; k < nbits; k++) begin
      next_tick();
      bits = {bits[30:0], get_tx(ch)};
    end
  endtask

  logic [7:0]  words  [6];
  logic [9:0]  frames [6];
  logic [31:0] b;
  bit          hi_s;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    nrst     = 1'b0;
    cts_n    = 1'b0;
    for (int c = 0; c < 5; c++) drive_valid(c, 1'b0, 8'h00);
    words  = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81, 8'h7E};
    frames = '{10'b0101001011, 10'b0001111001, 10'b0111100001,
               10'b0000011111, 10'b0100000011, 10'b0011111101};

    #23;
    check("rst_tx", tx_line[0], 1'b1);
    check("rst_busy", busy[0], 1'b0);
    check("rst_level", lvl[0], 3'd0);
    check("rst_ready", get_ready(0), 1'b1);
    @(negedge clk);
    nrst = 1'b1;

    // Single frames in each format
    push(0, 8'hA5);
    collect(0, 10, b);
    check("n1_a5", b, 32'b0101001011);
    check("n1_busy_stop", busy[0], 1'b1);
    next_tick();
    check("n1_busy_done", busy[0], 1'b0);
    check("n1_idle_tx", tx_line[0], 1'b1);

    push(1, 8'hA5);
    collect(1, 11, b);
    check("e1_a5", b, 32'b01010010101);
    push(2, 8'hA5);
    collect(2, 11, b);
    check("o1_a5", b, 32'b01010010111);
    push(3, 8'hA5);
    collect(3, 11, b);
    check("n2_a5", b, 32'b01010010111);
    check("n2_busy_stop2", busy[3], 1'b1);
    next_tick();
    check("n2_busy_done", busy[3], 1'b0);

    // Five data bits, with CTS ignored on this instance
    cts_n = 1'b1;
    push(4, 8'hFF);
    collect(4, 7, b);
    check("d5_1f", b, 32'b0111111);
    push(4, 8'hEA);
    collect(4, 7, b);
    check("d5_0a", b, 32'b0010101);
    next_tick();
    check("d5_busy_done", busy[4], 1'b0);
    cts_n = 1'b0;

    // Burst of six words into a four-deep FIFO
    next_tick();
    fork
      begin
        for (int i = 0; i < 4; i++) push(0, words[i]);
        @(negedge clk);
        check("burst_level_full", lvl[0], 3'd4);
        check("burst_ready_low", get_ready(0), 1'b0);
        for (int i = 4; i < 6; i++) push(0, words[i]);
      end
      begin
        collect(0, 10, b);
        check("burst_f0", b, {22'd0, frames[0]});
        for (int f = 1; f < 6; f++) begin
          b = 32'd0;
          for (int k = 0; k < 10; k++) begin
            next_tick();
            b = {b[30:0], get_tx(0)};
          end
          check($sformatf("burst_f%0d", f), b, {22'd0, frames[f]});
        end
      end
    join
    next_tick();
    check("burst_busy_done", busy[0], 1'b0);

    // Flow control: hold while cts_n high, finish the frame in flight when it rises again
    cts_n = 1'b1;
    repeat (4) @(negedge clk);
    push(0, 8'h55);
    push(0, 8'h33);
    hi_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_tick();
      if (tx_line[0] !== 1'b1) hi_s = 1'b0;
    end
    check("cts_hold_tx", hi_s, 1'b1);
    check("cts_hold_level", lvl[0], 3'd2);
    @(negedge clk);
    cts_n = 1'b0;
    next_tick();
    check("cts_release_start", tx_line[0], 1'b0);
    b = 32'd0;
    for (int k = 1; k < 10; k++) begin
      next_tick();
      b = {b[30:0], tx_line[0]};
      if (k == 2) cts_n = 1'b1;
    end
    check("cts_frame_55", b, 32'b0101010101);
    hi_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_tick();
      if (tx_line[0] !== 1'b1) hi_s = 1'b0;
    end
    check("cts_idle_tx", hi_s, 1'b1);
    check("cts_idle_level", lvl[0], 3'd1);
    cts_n = 1'b0;
    collect(0, 10, b);
    check("cts_frame_33", b, 32'b0110011001);
    next_tick();

    // Asynchronous reset in the middle of the data bits
    push(0, 8'h00);
    push(0, 8'h00);
    wait_start(0);
    next_tick();
    next_tick();
    check("prerst_tx", tx_line[0], 1'b0);
    @(posedge clk);
    #3;
    nrst = 1'b0;
    #1;
    check("midrst_tx", tx_line[0], 1'b1);
    check("midrst_level", lvl[0], 3'd0);
    check("midrst_busy", busy[0], 1'b0);
    check("midrst_ready", get_ready(0), 1'b1);
    @(negedge clk);
    nrst = 1'b1;
    push(0, 8'h3C);
    collect(0, 10, b);
    check("postrst_3c", b, 32'b0001111001);
    next_tick();
    check("postrst_busy_done", busy[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
